// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its wait-state counter.
package dmem_arb_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_e;

   typedef logic port_idx_t;

   typedef enum logic {
      OP_RD,
      OP_WR
   } op_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Two requester ports plus the memory-side bus of the data-memory arbiter.
// slave: arbiter view; master: requesters and memory view.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic              p0_r_en;
   logic              p0_w_en;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic [DATA_W-1:0] p0_rdata;
   logic              p0_ready;

   logic              p1_r_en;
   logic              p1_w_en;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic [DATA_W-1:0] p1_rdata;
   logic              p1_ready;

   logic              mem_r_en;
   logic              mem_w_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              freeze;
   logic              grant;

   modport slave (
      input  p0_r_en, p0_w_en, p0_addr, p0_wdata,
      input  p1_r_en, p1_w_en, p1_addr, p1_wdata,
      input  mem_rdata,
      output p0_rdata, p0_ready, p1_rdata, p1_ready,
      output mem_r_en, mem_w_en, mem_addr, mem_wdata,
      output freeze, grant
   );

   modport master (
      output p0_r_en, p0_w_en, p0_addr, p0_wdata,
      output p1_r_en, p1_w_en, p1_addr, p1_wdata,
      output mem_rdata,
      input  p0_rdata, p0_ready, p1_rdata, p1_ready,
      input  mem_r_en, mem_w_en, mem_addr, mem_wdata,
      input  freeze, grant
   );

endinterface

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter with synchronous reset; stops at zero and flags it.
module dmem_wait_counter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned WIDTH = CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port sequencer/arbiter in front of the data memory with WAIT_CYCLES wait states.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);

   state_e            r_state;
   state_e            w_state_next;
   port_idx_t         r_grant;
   port_idx_t         w_winner;
   op_e               r_op;
   op_e               w_req_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_p0_rdata;
   logic [DATA_W-1:0] r_p1_rdata;
   logic [DATA_W-1:0] w_rd_val;
   logic              w_p0_req;
   logic              w_p1_req;
   logic              w_start;
   logic              w_strobe;
   logic              w_dec;
   logic              w_cnt_zero;
   logic              w_p0_ready;
   logic              w_p1_ready;

   assign w_p0_req = bus.p0_r_en | bus.p0_w_en;
   assign w_p1_req = bus.p1_r_en | bus.p1_w_en;

`ifdef DMEM_ARB_RR_EN
   port_idx_t r_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b0;
      end else if (w_start) begin
         r_last <= w_winner;
      end
   end

   // On conflict the port not granted last time wins; a lone requester always wins.
   assign w_winner = (w_p0_req && w_p1_req) ? ~r_last : w_p1_req;
`else
   assign w_winner = ~w_p0_req;
`endif

   // Both enables set means write.
   always_comb begin
      w_req_op = OP_RD;
      if (w_winner == 1'b0) begin
         if (bus.p0_w_en) w_req_op = OP_WR;
      end else begin
         if (bus.p1_w_en) w_req_op = OP_WR;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_strobe     = 1'b0;
      w_dec        = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_p0_req || w_p1_req) begin
               w_start      = 1'b1;
               w_state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (w_cnt_zero) begin
               w_strobe     = 1'b1;
               w_state_next = DONE;
            end else begin
               w_dec = 1'b1;
            end
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   dmem_wait_counter #(
      .WIDTH(CNT_W)
   ) u_wait_counter (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_start),
      .i_load_val (CNT_W'(WAIT_CYCLES)),
      .i_dec      (w_dec),
      .o_zero     (w_cnt_zero)
   );

   assign w_rd_val = (r_op == OP_RD) ? bus.mem_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_grant    <= 1'b0;
         r_op       <= OP_RD;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_p0_rdata <= '0;
         r_p1_rdata <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_start) begin
            r_grant <= w_winner;
            r_op    <= w_req_op;
            r_addr  <= w_winner ? bus.p1_addr : bus.p0_addr;
            r_wdata <= w_winner ? bus.p1_wdata : bus.p0_wdata;
         end
         if (w_strobe) begin
            if (r_grant) r_p1_rdata <= w_rd_val;
            else         r_p0_rdata <= w_rd_val;
         end
      end
   end

   // Strobes gated by reset so a reset in the strobe cycle never writes.
   assign bus.mem_r_en  = w_strobe & (r_op == OP_RD) & ~rst;
   assign bus.mem_w_en  = w_strobe & (r_op == OP_WR) & ~rst;
   assign bus.mem_addr  = (r_state == IDLE) ? '0 : r_addr;
   assign bus.mem_wdata = (r_state == IDLE) ? '0 : r_wdata;

   assign w_p0_ready   = (r_state == DONE) & ~r_grant;
   assign w_p1_ready   = (r_state == DONE) & r_grant;
   assign bus.p0_ready = w_p0_ready;
   assign bus.p1_ready = w_p1_ready;
   assign bus.p0_rdata = r_p0_rdata;
   assign bus.p1_rdata = r_p1_rdata;
   assign bus.freeze   = w_p0_req & ~w_p0_ready;
   assign bus.grant    = r_grant;

endmodule
